// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy obstacle field.
// PIPE_BCD_SCORE_EN (consumed in pipe_field) selects a packed-BCD score.
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HIT
    } field_state_t;

    localparam logic [7:0]  LFSR_SEED = 8'hA5;
    localparam int unsigned GAP_BASE  = 120;
    localparam int unsigned GAP_RESET = 240;
    localparam int unsigned SCREEN_W  = 640;
    localparam int unsigned SCREEN_H  = 480;
    localparam int unsigned PIPE_XW   = 11;

endpackage

// File: rtl/pipe_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) feeding the pipe gap heights.
module pipe_lfsr
    import flappy_pkg::*;
(
    input  logic       clk_60Hz,
    input  logic       rst,
    output logic [7:0] value
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk_60Hz) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/pipe_field.sv
// Scrolling pipe ring with collision detection and score for the Bruin.
// Define PIPE_BCD_SCORE_EN for a two-digit packed-BCD score (saturates at 99).
module pipe_field
    import flappy_pkg::*;
#(
    parameter int unsigned NUM_PIPES = 4,
    parameter int unsigned PIPE_W    = 40,
    parameter int unsigned GAP_H     = 120,
    parameter int unsigned SPACING   = 160,
    parameter int unsigned SCROLL    = 2,
    parameter int unsigned SCREEN_W  = flappy_pkg::SCREEN_W
) (
    input  logic                            clk_60Hz,
    input  logic                            rst,
    input  logic                            game_start,
    input  logic [8:0]                      bruin_x,
    input  logic [8:0]                      bruin_y,
    input  logic [4:0]                      bruin_high,
    input  logic [4:0]                      bruin_width,
    input  logic                            bruin_game_over,
    output logic [NUM_PIPES-1:0][PIPE_XW-1:0] pipe_x,
    output logic [NUM_PIPES-1:0][8:0]       pipe_gap_y,
    output logic                            lose,
    output logic [7:0]                      score
);

    typedef logic [PIPE_XW-1:0] px_t;

    localparam px_t SCROLL_X = px_t'(SCROLL);
    localparam px_t WRAP_ADD = px_t'(NUM_PIPES * SPACING - SCROLL);
    localparam px_t PIPE_WX  = px_t'(PIPE_W);
    localparam px_t HALF_GAP = px_t'(GAP_H / 2);
`ifdef PIPE_BCD_SCORE_EN
    localparam logic [7:0] SCORE_MAX = 8'h99;
`else
    localparam logic [7:0] SCORE_MAX = 8'hFF;
`endif

    field_state_t state_q, state_d;
    px_t  [NUM_PIPES-1:0] px_q, px_d;
    logic [NUM_PIPES-1:0][8:0] gap_q, gap_d;
    logic [7:0] score_q, score_d;
    logic [7:0] lfsr;
    logic [NUM_PIPES-1:0] hit_v, cross_v;
    logic run_en, any_hit;
    px_t bx0, bx1, by0, by1;

    pipe_lfsr u_lfsr (
        .clk_60Hz (clk_60Hz),
        .rst      (rst),
        .value    (lfsr)
    );

    // IDLE with game_start already scrolls, so the first moving edge is the start edge.
    assign run_en  = game_start && (state_q != HIT);
    assign any_hit = (|hit_v) || bruin_game_over;

    assign bx0 = {2'b00, bruin_x} - ({6'd0, bruin_width} >> 1);
    assign bx1 = {2'b00, bruin_x} + ({6'd0, bruin_width} >> 1);
    assign by0 = {2'b00, bruin_y} - ({6'd0, bruin_high} >> 1);
    assign by1 = {2'b00, bruin_y} + ({6'd0, bruin_high} >> 1);

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
        px_t nxt, gap_lo, gap_hi;
        logic wrap;

        assign wrap   = px_q[i] < SCROLL_X;
        assign nxt    = wrap ? px_q[i] + WRAP_ADD : px_q[i] - SCROLL_X;
        assign gap_lo = {2'b00, gap_q[i]} - HALF_GAP;
        assign gap_hi = {2'b00, gap_q[i]} + HALF_GAP;

        // Left-edge test written as px < bx1 + W so a pipe near x=0 cannot underflow.
        assign hit_v[i]   = (bx0 < px_q[i]) && (px_q[i] < bx1 + PIPE_WX)
                            && !((by0 >= gap_lo) && (by1 <= gap_hi));
        assign cross_v[i] = (px_q[i] >= bx0) && (nxt < bx0);

        assign px_d[i]  = run_en ? nxt : px_q[i];
        assign gap_d[i] = (run_en && wrap) ? 9'(GAP_BASE) + {1'b0, lfsr} : gap_q[i];
    end

    always_ff @(posedge clk_60Hz) begin
        if (rst) begin
            state_q <= IDLE;
            score_q <= '0;
            for (int unsigned i = 0; i < NUM_PIPES; i++) begin
                px_q[i]  <= px_t'(SCREEN_W + PIPE_W + i * SPACING);
                gap_q[i] <= 9'(GAP_RESET);
            end
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            px_q    <= px_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RUN: if (run_en) state_d = any_hit ? HIT : RUN;
            HIT:       state_d = HIT;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        lose = (state_q == HIT);
    end

    always_comb begin
        score_d = score_q;
        if (run_en && !any_hit && (|cross_v) && (score_q != SCORE_MAX)) begin
`ifdef PIPE_BCD_SCORE_EN
            if (score_q[3:0] == 4'd9) begin
                score_d = {score_q[7:4] + 4'd1, 4'd0};
            end else begin
                score_d = score_q + 8'd1;
            end
`else
            score_d = score_q + 8'd1;
`endif
        end
    end

    assign pipe_x     = px_q;
    assign pipe_gap_y = gap_q;
    assign score      = score_q;

endmodule

// File: tb/tb_pipe_field.sv
// Self-checking bench for pipe_field: directed scenarios plus randomized play
// checked every frame against an integer reference model of the field.
module tb_pipe_field;

    localparam int NP = 4;

    logic clk_60Hz = 1'b0;
    logic rst, game_start, bruin_game_over;
    logic [8:0] bruin_x, bruin_y;
    logic [4:0] bruin_high, bruin_width;
    logic [NP-1:0][10:0] pipe_x;
    logic [NP-1:0][8:0] pipe_gap_y;
    logic lose;
    logic [7:0] score;

    int n_checks = 0;
    int n_fail   = 0;

    int m_px[NP];
    int m_gap[NP];
    int m_cnt;
    int m_lfsr;
    int m_pre_lfsr;
    bit m_dead;

    always #5 clk_60Hz = ~clk_60Hz;

    pipe_field #(
        .NUM_PIPES (4),
        .PIPE_W    (40),
        .GAP_H     (120),
        .SPACING   (160),
        .SCROLL    (2),
        .SCREEN_W  (640)
    ) dut (
        .clk_60Hz        (clk_60Hz),
        .rst             (rst),
        .game_start      (game_start),
        .bruin_x         (bruin_x),
        .bruin_y         (bruin_y),
        .bruin_high      (bruin_high),
        .bruin_width     (bruin_width),
        .bruin_game_over (bruin_game_over),
        .pipe_x          (pipe_x),
        .pipe_gap_y      (pipe_gap_y),
        .lose            (lose),
        .score           (score)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int score_view(input int cnt);
`ifdef PIPE_BCD_SCORE_EN
        int c;
        c = (cnt > 99) ? 99 : cnt;
        return (c / 10) * 16 + (c % 10);
`else
        return (cnt > 255) ? 255 : cnt;
`endif
    endfunction

    // One frame of the reference model, using the inputs presented before the edge.
    task automatic model_step();
        int bx0, bx1, by0, by1, nx, fb;
        bit hit, crossed;
        m_pre_lfsr = m_lfsr;
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                m_px[i]  = 640 + 40 + i * 160;
                m_gap[i] = 240;
            end
            m_cnt  = 0;
            m_dead = 0;
            m_lfsr = 8'hA5;
            return;
        end
        if (!m_dead && game_start) begin
            bx0 = bruin_x - bruin_width / 2;
            bx1 = bruin_x + bruin_width / 2;
            by0 = bruin_y - bruin_high / 2;
            by1 = bruin_y + bruin_high / 2;
            hit = bruin_game_over;
            crossed = 0;
            for (int i = 0; i < NP; i++) begin
                if (bx0 < m_px[i] && m_px[i] - 40 < bx1 &&
                    !(by0 >= m_gap[i] - 60 && by1 <= m_gap[i] + 60))
                    hit = 1;
                if (m_px[i] < 2) begin
                    nx = m_px[i] + 4 * 160 - 2;
                    m_gap[i] = 120 + m_lfsr;
                end else begin
                    nx = m_px[i] - 2;
                end
                if (m_px[i] >= bx0 && nx < bx0) crossed = 1;
                m_px[i] = nx;
            end
            if (!hit && crossed) m_cnt++;
            m_dead = hit;
        end
        fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
        m_lfsr = ((m_lfsr << 1) & 8'hFF) | fb;
    endtask

    task automatic compare_all();
        for (int i = 0; i < NP; i++) begin
            check($sformatf("pipe_x[%0d]", i), pipe_x[i], m_px[i]);
            check($sformatf("gap[%0d]", i), pipe_gap_y[i], m_gap[i]);
        end
        check("lose", lose, m_dead);
        check("score", score, score_view(m_cnt));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_60Hz);
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check_reset_pos(input string tag);
        check({tag, "_px0"}, pipe_x[0], 680);
        check({tag, "_px1"}, pipe_x[1], 840);
        check({tag, "_px2"}, pipe_x[2], 1000);
        check({tag, "_px3"}, pipe_x[3], 1160);
        check({tag, "_lose"}, lose, 0);
        check({tag, "_score"}, score, 0);
    endtask

    initial begin
        rst = 1; game_start = 0; bruin_game_over = 0;
        bruin_x = 150; bruin_width = 20; bruin_high = 20; bruin_y = 240;
        #2;
        tick();
        check_reset_pos("reset");
        check("reset_gap0", pipe_gap_y[0], 240);
        rst = 0;

        ticks(10);
        check_reset_pos("idle");

        game_start = 1;
        tick();
        check("start_px0", pipe_x[0], 678);
        ticks(240);
        check("t241_px0", pipe_x[0], 198);
        check("t241_lose", lose, 0);
        ticks(29);
        check("t270_score", score, 0);
        tick();
        check("t271_px0", pipe_x[0], 138);
        check("t271_score", score, 1);
        ticks(69);
        tick();
        check("t341_px0", pipe_x[0], 638);
        check("t341_px3", pipe_x[3], 478);
        check("t341_gap0", pipe_gap_y[0], 120 + m_pre_lfsr);

        game_start = 0;
        ticks(20);
        check("pause_px0", pipe_x[0], 638);
        check("pause_score", score, 1);

        game_start = 1; bruin_game_over = 1;
        tick();
        check("gameover_lose", lose, 1);
        bruin_game_over = 0;
        ticks(5);
        check("gameover_hold", lose, 1);

        rst = 1;
        tick();
        check_reset_pos("rst_hit");
        rst = 0;

        bruin_y = 100;
        ticks(241);
        check("low_t241_px0", pipe_x[0], 198);
        check("low_t241_lose", lose, 0);
        tick();
        check("low_hit_lose", lose, 1);
        ticks(10);
        rst = 1;
        tick();
        check_reset_pos("rst_after_low");
        rst = 0;

        for (int n = 0; n < 4000; n++) begin
            rst             = ($urandom_range(0, 299) == 0);
            game_start      = ($urandom_range(0, 9) != 0);
            bruin_game_over = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 19) == 0) begin
                bruin_x     = 9'($urandom_range(20, 300));
                bruin_width = 5'($urandom_range(2, 31));
                bruin_high  = 5'($urandom_range(2, 31));
            end
            bruin_y = 9'($urandom_range(0, 3) == 0 ? $urandom_range(60, 400)
                                                   : $urandom_range(200, 280));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
